// File: rtl/crop_window_detect.sv
// Per-frame bounding-box detector: classifies raster pixels against a frame-latched threshold
// and reports the inclusive hit window once per frame. Optional macro: CROP_RUNLEN_EN.
module crop_window_detect #(
  parameter int DATA_W   = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MIN_RUN  = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iTHRESH,
  input  logic              iMODE,
  output logic              oDVAL,
  output logic              oFOUND,
  output logic [15:0]       oXSTART,
  output logic [15:0]       oXEND,
  output logic [15:0]       oYSTART,
  output logic [15:0]       oYEND,
  output logic              state_dbg
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

  typedef enum logic {S_EMPTY = 1'b0, S_HIT = 1'b1} state_t;

  state_t            state;
  logic [15:0]       x_q, y_q;
  logic [15:0]       xmin_q, xmax_q, ymin_q, ymax_q;
  logic [DATA_W-1:0] thresh_q;
  logic              mode_q;
  logic              eof_q;

  logic [15:0]       px, py, cand_lo;
  logic [DATA_W-1:0] thr;
  logic              md, first_pix, pix_hit, reg_hit, restart, last_pix;
  state_t            st_eff;

  assign state_dbg = (state == S_HIT);

  // iSOF relocates the current pixel to (0,0); eof_q marks the reporting cycle,
  // in which the accumulators restart for a back-to-back frame.
  always_comb begin
    px        = iSOF ? 16'd0 : x_q;
    py        = iSOF ? 16'd0 : y_q;
    first_pix = (px == 16'd0) && (py == 16'd0);
    thr       = first_pix ? iTHRESH : thresh_q;
    md        = first_pix ? iMODE : mode_q;
    pix_hit   = iDVAL && (md ? (iDATA < thr) : (iDATA >= thr));
    restart   = iSOF || eof_q;
    st_eff    = restart ? S_EMPTY : state;
    last_pix  = iDVAL && (px == X_LAST) && (py == Y_LAST);
  end

`ifdef CROP_RUNLEN_EN
  localparam logic [15:0] RUN_MAX = 16'(MIN_RUN);
  logic [15:0] run_q, run_prev, run_new;

  // Run length saturates at MIN_RUN; column 0 always starts a fresh run.
  always_comb begin
    run_prev = (px == 16'd0) ? 16'd0 : run_q;
    run_new  = 16'd0;
    if (pix_hit) run_new = (run_prev == RUN_MAX) ? RUN_MAX : run_prev + 16'd1;
    reg_hit  = pix_hit && (run_new == RUN_MAX);
    cand_lo  = px - (RUN_MAX - 16'd1);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) run_q <= 16'd0;
    else if (iDVAL) run_q <= run_new;
  end
`else
  always_comb begin
    reg_hit = pix_hit && (MIN_RUN > 0);
    cand_lo = px;
  end
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state    <= S_EMPTY;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      xmin_q   <= 16'd0;
      xmax_q   <= 16'd0;
      ymin_q   <= 16'd0;
      ymax_q   <= 16'd0;
      thresh_q <= '0;
      mode_q   <= 1'b0;
      eof_q    <= 1'b0;
      oDVAL    <= 1'b0;
      oFOUND   <= 1'b0;
      oXSTART  <= 16'd0;
      oXEND    <= 16'd0;
      oYSTART  <= 16'd0;
      oYEND    <= 16'd0;
    end else begin
      oDVAL <= 1'b0;
      if (eof_q) begin
        oDVAL   <= 1'b1;
        oFOUND  <= (state == S_HIT);
        oXSTART <= (state == S_HIT) ? xmin_q : 16'd0;
        oXEND   <= (state == S_HIT) ? xmax_q : 16'd0;
        oYSTART <= (state == S_HIT) ? ymin_q : 16'd0;
        oYEND   <= (state == S_HIT) ? ymax_q : 16'd0;
      end
      eof_q <= last_pix;

      if (iDVAL) begin
        if (px == X_LAST) begin
          x_q <= 16'd0;
          y_q <= (py == Y_LAST) ? 16'd0 : py + 16'd1;
        end else begin
          x_q <= px + 16'd1;
          y_q <= py;
        end
        if (first_pix) begin
          thresh_q <= iTHRESH;
          mode_q   <= iMODE;
        end
      end else if (iSOF) begin
        x_q <= 16'd0;
        y_q <= 16'd0;
      end

      state <= st_eff;
      if (restart) begin
        xmin_q <= 16'd0;
        xmax_q <= 16'd0;
        ymin_q <= 16'd0;
        ymax_q <= 16'd0;
      end
      if (reg_hit) begin
        case (st_eff)
          S_EMPTY: begin
            xmin_q <= cand_lo;
            xmax_q <= px;
            ymin_q <= py;
            ymax_q <= py;
            state  <= S_HIT;
          end
          S_HIT: begin
            if (cand_lo < xmin_q) xmin_q <= cand_lo;
            if (px > xmax_q) xmax_q <= px;
            ymax_q <= py;
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crop_window_detect.sv
// Scoreboard bench for crop_window_detect on an 8x4 raster; expected windows come from a
// whole-frame reference model (run-length rule applied when CROP_RUNLEN_EN is defined).
module tb_crop_window_detect;
  localparam int DW = 10;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int MR = 2;
  localparam int W  = 65;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dval = 1'b0;
  logic          sof = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] thresh = '0;
  logic          o_dval, o_found, st;
  logic [15:0]   o_xs, o_xe, o_ys, o_ye;

  int          frame_px [V][H];
  logic [W-1:0] exp_q[$];
  int          pulse_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  crop_window_detect #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .MIN_RUN(MR)) dut (
    .iCLK(clk), .iRST(rst), .iDVAL(dval), .iDATA(data), .iSOF(sof),
    .iTHRESH(thresh), .iMODE(mode), .oDVAL(o_dval), .oFOUND(o_found),
    .oXSTART(o_xs), .oXEND(o_xe), .oYSTART(o_ys), .oYEND(o_ye), .state_dbg(st)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d reports outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: hit map, optional run qualification, then bounding box of qualified pixels.
  function automatic logic [W-1:0] model_frame(input int t, input bit m);
    bit h [V][H];
    bit q [V][H];
    int xs, xe, ys, ye;
    bit found;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        h[y][x] = m ? (frame_px[y][x] < t) : (frame_px[y][x] >= t);
        q[y][x] = 1'b0;
      end
`ifdef CROP_RUNLEN_EN
    for (int y = 0; y < V; y++) begin
      int s;
      s = 0;
      for (int x = 0; x <= H; x++) begin
        if (x == H || !h[y][x]) begin
          if (x - s >= MR)
            for (int k = s; k < x; k++) q[y][k] = 1'b1;
          s = x + 1;
        end
      end
    end
`else
    q = h;
`endif
    found = 1'b0;
    xs = H; xe = -1; ys = V; ye = -1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (q[y][x]) begin
          found = 1'b1;
          if (x < xs) xs = x;
          if (x > xe) xe = x;
          if (y < ys) ys = y;
          if (y > ye) ye = y;
        end
    if (!found) return '0;
    return {1'b1, 16'(xs), 16'(xe), 16'(ys), 16'(ye)};
  endfunction

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (o_dval === 1'b1) begin
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: got window %h, expected no report",
                   {o_found, o_xs, o_xe, o_ys, o_ye});
        end else begin
          check("report", {o_found, o_xs, o_xe, o_ys, o_ye}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input int d, input bit s, input int t, input bit m);
    @(negedge clk);
    dval = 1'b1; data = DW'(d); sof = s; thresh = DW'(t); mode = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dval = 1'b0; sof = 1'b0; data = DW'($urandom_range(0, 1023));
    end
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) frame_px[y][x] = v;
  endtask

  task automatic send_frame(input int t, input bit m, input bit s0, input bit gaps,
                            input int chg_at, input int t2, input bit m2);
    exp_q.push_back(model_frame(t, m));
    for (int i = 0; i < H * V; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive(frame_px[i / H][i % H], (i == 0) && s0,
            (i >= chg_at) ? t2 : t, (i >= chg_at) ? m2 : m);
    end
  endtask

  task automatic send_partial(input int n, input int t, input bit m);
    for (int i = 0; i < n; i++) drive(frame_px[i / H][i % H], 1'b0, t, m);
  endtask

  task automatic random_fill(input int t, input bit m);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        bit hv;
        hv = ($urandom_range(0, 3) == 0);
        if (hv ^ m) frame_px[y][x] = $urandom_range(t, 1023);
        else        frame_px[y][x] = $urandom_range(0, t - 1);
      end
  endtask

  initial begin
    int t, t2;
    bit m, m2;
    repeat (3) @(negedge clk);
    check("reset_dval", W'(o_dval), '0);
    check("reset_window", {o_found, o_xs, o_xe, o_ys, o_ye}, '0);
    rst = 1'b1;
    idle(2);

    // single bright pixel
    fill_const(0);
    frame_px[2][5] = 900;
    send_frame(512, 1'b0, 1'b0, 1'b0, H * V, 0, 1'b0);
    idle(4);

    // block with mid-frame threshold change, two frames back-to-back
    fill_const(0);
    for (int y = 1; y <= 3; y++)
      for (int x = 2; x <= 6; x++) frame_px[y][x] = 600;
    pulse_cyc.delete();
    send_frame(512, 1'b0, 1'b0, 1'b0, 10, 1000, 1'b0);
    send_frame(512, 1'b0, 1'b0, 1'b0, 10, 1000, 1'b0);
    idle(4);
    checks++;
    if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != H * V) begin
      errors++;
      $display("FAIL b2b_gap: got %0d pulses gap %0d, expected 2 pulses gap %0d",
               pulse_cyc.size(), (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1, H * V);
    end

    // dark-object mode, corners
    fill_const(500);
    frame_px[0][0] = 50;
    frame_px[3][7] = 50;
    send_frame(100, 1'b1, 1'b0, 1'b0, H * V, 0, 1'b0);
    idle(4);

    // abort at (3,2), then a frame with one hit at (1,1)
    fill_const(0);
    for (int x = 1; x <= 3; x++) frame_px[0][x] = 900;
    frame_px[2][1] = 900;
    send_partial(19, 512, 1'b0);
    fill_const(0);
    frame_px[1][1] = 900;
    send_frame(512, 1'b0, 1'b1, 1'b0, H * V, 0, 1'b0);
    idle(4);

    // iSOF on what would be the last pixel of a frame
    fill_const(900);
    send_partial(H * V - 1, 512, 1'b0);
    fill_const(0);
    frame_px[1][1] = 900;
    frame_px[1][2] = 900;
    send_frame(512, 1'b0, 1'b1, 1'b0, H * V, 0, 1'b0);
    idle(4);

    // reset mid-frame
    fill_const(900);
    send_partial(10, 512, 1'b0);
    @(negedge clk);
    rst = 1'b0; dval = 1'b0;
    @(negedge clk);
    check("midreset_dval", W'(o_dval), '0);
    check("midreset_window", {o_found, o_xs, o_xe, o_ys, o_ye}, '0);
    rst = 1'b1;
    idle(1);

    // bottom-right corner only, then a mix of a single pixel and a 4-long run
    fill_const(0);
    frame_px[3][7] = 1023;
    send_frame(512, 1'b0, 1'b0, 1'b0, H * V, 0, 1'b0);
    fill_const(0);
    frame_px[0][0] = 700;
    for (int x = 4; x <= 7; x++) frame_px[2][x] = 700;
    send_frame(512, 1'b0, 1'b0, 1'b0, H * V, 0, 1'b0);
    idle(3);

    // empty frame
    fill_const(0);
    send_frame(512, 1'b0, 1'b0, 1'b1, H * V, 0, 1'b0);
    idle(3);

    // randomized frames with idle gaps and ignored mid-frame threshold/mode changes
    for (int n = 0; n < 12; n++) begin
      t  = $urandom_range(1, 1023);
      m  = 1'($urandom_range(0, 1));
      t2 = $urandom_range(0, 1023);
      m2 = 1'($urandom_range(0, 1));
      random_fill(t, m);
      send_frame(t, m, 1'b0, 1'b1, $urandom_range(1, H * V - 1), t2, m2);
    end
    idle(4);

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_report: got %0d reports outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
